// File: rtl/ball_paddle_engine_if.sv
// Game-engine bus: tick strobe and buttons in, paddle/ball coordinates, lives and state out.
// master drives the tick and buttons; slave is the engine.
interface ball_paddle_engine_if #(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 10
);
  logic           tick;
  logic           btn_left;
  logic           btn_right;
  logic           btn_serve;
  logic [X_W-1:0] paddle_x;
  logic [Y_W-1:0] paddle_y;
  logic [X_W-1:0] ball_x;
  logic [Y_W-1:0] ball_y;
  logic [2:0]     lives;
  logic [1:0]     state;
  logic           hit;
  logic           miss;

  modport master (
    output tick, btn_left, btn_right, btn_serve,
    input  paddle_x, paddle_y, ball_x, ball_y, lives, state, hit, miss
  );

  modport slave (
    input  tick, btn_left, btn_right, btn_serve,
    output paddle_x, paddle_y, ball_x, ball_y, lives, state, hit, miss
  );
endinterface

// File: rtl/ball_paddle_engine.sv
// Breakout engine: paddle, ball with signed velocity, wall and paddle bounces, lives, game FSM.
// State advances only on clk edges where the per-frame tick strobe is high.
module ball_paddle_engine #(
  parameter int unsigned SCREEN_W    = 1440,
  parameter int unsigned SCREEN_H    = 900,
  parameter int unsigned X_W         = 11,
  parameter int unsigned Y_W         = 10,
  parameter int unsigned PADDLE_W    = 140,
  parameter int unsigned PADDLE_Y    = 850,
  parameter int unsigned PADDLE_STEP = 10,
  parameter int unsigned BALL_SIZE   = 10,
  parameter int unsigned BALL_VX     = 4,
  parameter int unsigned BALL_VY     = 4,
  parameter int unsigned LIVES       = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  ball_paddle_engine_if.slave bus
);
  localparam int unsigned XS = X_W + 2;
  localparam int unsigned YS = Y_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SERVE = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_OVER  = 2'b11;

  localparam logic [X_W-1:0] PX_MAX     = X_W'(SCREEN_W - PADDLE_W);
  localparam logic [X_W-1:0] PX_INIT    = X_W'((SCREEN_W - PADDLE_W) / 2);
  localparam logic [X_W-1:0] STEP       = X_W'(PADDLE_STEP);
  localparam logic [X_W-1:0] PARK_OFS   = X_W'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [X_W-1:0] BX_MAX     = X_W'(SCREEN_W - BALL_SIZE);
  localparam logic [Y_W-1:0] PARK_Y     = Y_W'(PADDLE_Y - BALL_SIZE);
  localparam logic [Y_W-1:0] PADDLE_ROW = Y_W'(PADDLE_Y);
  localparam logic [2:0]     LIVES_INIT = 3'(LIVES);

  localparam logic signed [XS-1:0] ZERO_X   = '0;
  localparam logic signed [YS-1:0] ZERO_Y   = '0;
  localparam logic signed [XS-1:0] VX_POS   = XS'(BALL_VX);
  localparam logic signed [XS-1:0] VX_NEG   = -VX_POS;
  localparam logic signed [YS-1:0] VY_POS   = YS'(BALL_VY);
  localparam logic signed [YS-1:0] VY_NEG   = -VY_POS;
  localparam logic signed [XS-1:0] BX_MAX_S = XS'(SCREEN_W - BALL_SIZE);
  localparam logic signed [XS-1:0] BSZ_X    = XS'(BALL_SIZE);
  localparam logic signed [XS-1:0] BHALF_X  = XS'(BALL_SIZE / 2);
  localparam logic signed [XS-1:0] PW_X     = XS'(PADDLE_W);
  localparam logic signed [XS-1:0] THIRD_LO = XS'(PADDLE_W / 3);
  localparam logic signed [XS-1:0] THIRD_HI = XS'(PADDLE_W - PADDLE_W / 3);
  localparam logic signed [YS-1:0] BSZ_Y    = YS'(BALL_SIZE);
  localparam logic signed [YS-1:0] PY_S     = YS'(PADDLE_Y);
  localparam logic signed [YS-1:0] BY_MAX_S = YS'(SCREEN_H - BALL_SIZE);

  logic [X_W-1:0]        px_q, px_d, bx_q, bx_d;
  logic [Y_W-1:0]        by_q, by_d;
  logic signed [XS-1:0]  vx_q, vx_d;
  logic signed [YS-1:0]  vy_q, vy_d;
  logic [2:0]            lives_q, lives_d;
  logic [1:0]            state_q, state_d;
  logic                  hit_q, hit_d, miss_q, miss_d;
  logic                  serve_prev_q, serve_prev_d;

  logic                  serve_edge;
  logic [X_W:0]          px_sum;
  logic [X_W-1:0]        px_new, park_x, nxc;
  logic signed [XS-1:0]  nx, nxc_s, px_s, rel, vx_wall;
  logic signed [YS-1:0]  ny, by_s;
  logic                  hit_c;

  assign serve_edge = bus.btn_serve & ~serve_prev_q;

  // Paddle moves only while a ball is in hand or in flight.
  always_comb begin
    px_new = px_q;
    px_sum = {1'b0, px_q} + {1'b0, STEP};
    if (state_q == ST_SERVE || state_q == ST_PLAY) begin
      if (bus.btn_left && !bus.btn_right) begin
        px_new = (px_q >= STEP) ? px_q - STEP : '0;
      end else if (bus.btn_right && !bus.btn_left) begin
        px_new = (px_sum >= {1'b0, PX_MAX}) ? PX_MAX : px_sum[X_W-1:0];
      end
    end
  end

  assign park_x = px_new + PARK_OFS;

  // Ball step: horizontal wall clamp first, then vertical and paddle tests use the clamped x.
  always_comb begin
    nx      = $signed({2'b00, bx_q}) + vx_q;
    ny      = $signed({2'b00, by_q}) + vy_q;
    by_s    = $signed({2'b00, by_q});
    px_s    = $signed({2'b00, px_new});
    vx_wall = vx_q;
    nxc     = nx[X_W-1:0];
    if (nx <= ZERO_X) begin
      nxc     = '0;
      vx_wall = VX_POS;
    end else if (nx >= BX_MAX_S) begin
      nxc     = BX_MAX;
      vx_wall = VX_NEG;
    end
    nxc_s = $signed({2'b00, nxc});
    rel   = nxc_s + BHALF_X - px_s;
    hit_c = (vy_q > ZERO_Y) && (by_s + BSZ_Y <= PY_S) && (ny + BSZ_Y >= PY_S) &&
            (nxc_s + BSZ_X > px_s) && (nxc_s < px_s + PW_X);
  end

  always_comb begin
    px_d         = px_q;
    bx_d         = bx_q;
    by_d         = by_q;
    vx_d         = vx_q;
    vy_d         = vy_q;
    lives_d      = lives_q;
    state_d      = state_q;
    serve_prev_d = serve_prev_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    if (bus.tick) begin
      serve_prev_d = bus.btn_serve;
      px_d         = px_new;
      case (state_q)
        ST_IDLE: begin
          bx_d = park_x;
          by_d = PARK_Y;
          if (serve_edge) state_d = ST_SERVE;
        end
        ST_SERVE: begin
          bx_d = park_x;
          by_d = PARK_Y;
          if (serve_edge) begin
            state_d = ST_PLAY;
            vx_d    = VX_POS;
            vy_d    = VY_NEG;
          end
        end
        ST_PLAY: begin
          bx_d = nxc;
          vx_d = vx_wall;
          if (ny <= ZERO_Y) begin
            by_d = '0;
            vy_d = VY_POS;
          end else if (hit_c) begin
            by_d  = PARK_Y;
            vy_d  = VY_NEG;
            hit_d = 1'b1;
            if (rel < THIRD_LO) vx_d = VX_NEG;
            else if (rel >= THIRD_HI) vx_d = VX_POS;
          end else if (ny >= BY_MAX_S) begin
            miss_d = 1'b1;
            bx_d   = park_x;
            by_d   = PARK_Y;
            if (lives_q > 3'd1) begin
              lives_d = lives_q - 3'd1;
              state_d = ST_SERVE;
            end else begin
              lives_d = '0;
              state_d = ST_OVER;
            end
          end else begin
            by_d = ny[Y_W-1:0];
          end
        end
        default: begin
          if (serve_edge) begin
            state_d = ST_IDLE;
            lives_d = LIVES_INIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px_q         <= PX_INIT;
      bx_q         <= PX_INIT + PARK_OFS;
      by_q         <= PARK_Y;
      vx_q         <= VX_POS;
      vy_q         <= VY_NEG;
      lives_q      <= LIVES_INIT;
      state_q      <= ST_IDLE;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      serve_prev_q <= 1'b0;
    end else begin
      px_q         <= px_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      vx_q         <= vx_d;
      vy_q         <= vy_d;
      lives_q      <= lives_d;
      state_q      <= state_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      serve_prev_q <= serve_prev_d;
    end
  end

  assign bus.paddle_x = px_q;
  assign bus.paddle_y = PADDLE_ROW;
  assign bus.ball_x   = bx_q;
  assign bus.ball_y   = by_q;
  assign bus.lives    = lives_q;
  assign bus.state    = state_q;
  assign bus.hit      = hit_q;
  assign bus.miss     = miss_q;
endmodule

// File: tb/tb_ball_paddle_engine.sv
// Scoreboard bench for ball_paddle_engine: each tick queues the expected outputs,
// a monitor compares them on the falling edge after the tick is taken.
module tb_ball_paddle_engine;
  logic clk;
  logic rst_n;

  ball_paddle_engine_if #(.X_W(11), .Y_W(10)) bus ();

  ball_paddle_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string name;
    int    px, bx, by, lives, state, hit, miss;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Behavioural game model, default parameters written out as plain numbers.
  int m_px, m_bx, m_by, m_vx, m_vy, m_lives, m_state;
  bit m_sprev, m_hit, m_miss;

  // Hand-computed overrides for the next queued entry; -1 means take the model value.
  int h_px = -1, h_bx = -1, h_by = -1, h_lives = -1, h_state = -1, h_hit = -1, h_miss = -1;

  task automatic m_park();
    m_bx = m_px + 65;
    m_by = 840;
  endtask

  task automatic m_reset();
    m_px = 650; m_park(); m_lives = 3; m_state = 0;
    m_vx = 4; m_vy = -4; m_sprev = 0; m_hit = 0; m_miss = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit s);
    int nx, ny, nxc, rel;
    bit edge_s;
    m_hit = 0; m_miss = 0;
    edge_s = s && !m_sprev;
    m_sprev = s;
    if (m_state == 1 || m_state == 2) begin
      if (l && !r) m_px = (m_px - 10 < 0) ? 0 : m_px - 10;
      if (r && !l) m_px = (m_px + 10 > 1300) ? 1300 : m_px + 10;
    end
    case (m_state)
      0: begin m_park(); if (edge_s) m_state = 1; end
      1: begin
        m_park();
        if (edge_s) begin m_state = 2; m_vx = 4; m_vy = -4; end
      end
      2: begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        if (nx <= 0) begin nxc = 0; m_vx = 4; end
        else if (nx >= 1430) begin nxc = 1430; m_vx = -4; end
        else nxc = nx;
        m_bx = nxc;
        if (ny <= 0) begin
          m_by = 0; m_vy = 4;
        end else if (m_vy > 0 && m_by + 10 <= 850 && ny + 10 >= 850 &&
                     nxc + 10 > m_px && nxc < m_px + 140) begin
          m_by = 840; m_vy = -4; m_hit = 1;
          rel = nxc + 5 - m_px;
          if (rel < 46) m_vx = -4;
          else if (rel >= 94) m_vx = 4;
        end else if (ny >= 890) begin
          m_miss = 1; m_lives = m_lives - 1; m_park();
          m_state = (m_lives == 0) ? 3 : 1;
        end else begin
          m_by = ny;
        end
      end
      default: if (edge_s) begin m_state = 0; m_lives = 3; end
    endcase
  endtask

  task automatic push_exp(input string nm);
    exp_t e;
    e.name  = nm;
    e.px    = (h_px    >= 0) ? h_px    : m_px;
    e.bx    = (h_bx    >= 0) ? h_bx    : m_bx;
    e.by    = (h_by    >= 0) ? h_by    : m_by;
    e.lives = (h_lives >= 0) ? h_lives : m_lives;
    e.state = (h_state >= 0) ? h_state : m_state;
    e.hit   = (h_hit   >= 0) ? h_hit   : int'(m_hit);
    e.miss  = (h_miss  >= 0) ? h_miss  : int'(m_miss);
    sb.push_back(e);
    h_px = -1; h_bx = -1; h_by = -1; h_lives = -1; h_state = -1; h_hit = -1; h_miss = -1;
  endtask

  task automatic hand_all(input int px, input int bx, input int by, input int lv, input int st);
    h_px = px; h_bx = bx; h_by = by; h_lives = lv; h_state = st; h_hit = 0; h_miss = 0;
  endtask

  task automatic do_tick(input bit l, input bit r, input bit s, input string nm);
    @(posedge clk); #2;
    bus.btn_left  = l;
    bus.btn_right = r;
    bus.btn_serve = s;
    bus.tick      = 1'b1;
    model_tick(l, r, s);
    push_exp(nm);
    @(posedge clk); #2;
    bus.tick = 1'b0;
  endtask

  task automatic do_reset(input bit tk, input string nm);
    @(posedge clk); #2;
    rst_n    = 1'b0;
    bus.tick = tk;
    m_reset();
    push_exp(nm);
    @(posedge clk); #2;
    rst_n         = 1'b1;
    bus.tick      = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_serve = 1'b0;
  endtask

  initial begin : monitor
    bit   pend;
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      pend = mon_en && (bus.tick || !rst_n);
      @(negedge clk);
      if (pend) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_update: DUT updated with no expected entry queued");
        end else begin
          e = sb.pop_front();
          if (int'(bus.paddle_x) != e.px || int'(bus.ball_x) != e.bx ||
              int'(bus.ball_y) != e.by || int'(bus.lives) != e.lives ||
              int'(bus.state) != e.state || int'(bus.hit) != e.hit ||
              int'(bus.miss) != e.miss || bus.paddle_y !== 10'd850) begin
            n_bad++;
            $display("FAIL %s: got px=%0d bx=%0d by=%0d py=%0d lives=%0d st=%0d hit=%0b miss=%0b, want px=%0d bx=%0d by=%0d py=850 lives=%0d st=%0d hit=%0d miss=%0d",
                     e.name, bus.paddle_x, bus.ball_x, bus.ball_y, bus.paddle_y, bus.lives,
                     bus.state, bus.hit, bus.miss, e.px, e.bx, e.by, e.lives, e.state,
                     e.hit, e.miss);
          end
        end
      end else if (prev) begin
        n_vec++;
        if (bus.hit !== 1'b0 || bus.miss !== 1'b0) begin
          n_bad++;
          $display("FAIL pulse_width: got hit=%0b miss=%0b, want hit=0 miss=0", bus.hit, bus.miss);
        end
      end
      prev = pend;
    end
  end

  initial begin : stimulus
    bit l, r, missed;
    rst_n = 1'b0;
    bus.tick = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_serve = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2 mon_en = 1'b1;

    hand_all(650, 715, 840, 3, 0); do_reset(1'b0, "reset");
    do_tick(0, 0, 0, "idle");
    do_tick(0, 0, 0, "idle");
    hand_all(650, 715, 840, 3, 0); do_tick(0, 0, 0, "idle_3");

    h_state = 1; do_tick(0, 0, 1, "serve_edge");
    repeat (3) do_tick(0, 0, 1, "serve_held");
    h_state = 1; do_tick(0, 0, 1, "serve_held_5");

    repeat (69) do_tick(0, 1, 0, "paddle_right");
    h_px = 1300; h_bx = 1365; do_tick(0, 1, 0, "paddle_right_sat");
    h_px = 1300; do_tick(1, 1, 0, "paddle_both_hold");
    repeat (134) do_tick(1, 0, 0, "paddle_left");
    h_px = 0; h_bx = 65; h_by = 840; do_tick(1, 0, 0, "paddle_left_sat");
    repeat (64) do_tick(0, 1, 0, "paddle_right");
    h_px = 650; h_bx = 715; do_tick(0, 1, 0, "paddle_centre");

    hand_all(650, 715, 840, 3, 2); do_tick(0, 0, 1, "play_start");

    // Long rally: right wall, ceiling, left-third hit, left wall, ceiling, left-third hit.
    for (int k = 1; k <= 841; k++) begin
      case (k)
        1:   begin h_bx = 719;  h_by = 836; end
        179: begin h_bx = 1430; h_by = 124; end
        180: begin h_bx = 1426; h_by = 120; end
        210: begin h_bx = 1306; h_by = 0;   end
        211: begin h_bx = 1302; h_by = 4;   end
        420: begin h_bx = 466;  h_by = 840; h_hit = 1; h_px = 460; end
        421: begin h_bx = 462;  h_by = 836; h_hit = 0; end
        537: begin h_bx = 0;    h_by = 372; end
        538: begin h_bx = 4;    h_by = 368; end
        630: begin h_bx = 372;  h_by = 0;   end
        840: begin h_bx = 1212; h_by = 840; h_hit = 1; h_px = 1180; end
        841: begin h_bx = 1208; h_by = 836; end
        default: ;
      endcase
      do_tick(k <= 19, k >= 422 && k <= 493, 0, "rally");
    end

    // Steer the paddle away from the ball until it is lost, three times.
    for (int n = 1; n <= 3; n++) begin
      missed = 1'b0;
      for (int t = 0; t < 4000 && !missed; t++) begin
        r = (m_bx < 715);
        l = !r;
        do_tick(l, r, 0, "play_run");
        missed = m_miss;
      end
      if (!missed) begin
        n_vec++; n_bad++;
        $display("FAIL miss_timeout: got no miss within 4000 ticks, want miss %0d", n);
      end
      h_lives = 3 - n; h_state = (n < 3) ? 1 : 3; do_tick(0, 0, 0, "after_miss");
      if (n < 3) begin
        h_state = 2; do_tick(0, 0, 1, "reserve");
      end
    end

    h_state = 0; h_lives = 3; do_tick(0, 0, 1, "restart");
    do_tick(0, 0, 0, "release");
    h_state = 1; do_tick(0, 0, 1, "serve_again");
    do_tick(0, 0, 0, "release");
    h_state = 2; do_tick(0, 0, 1, "play_again");
    repeat (5) do_tick(0, 1, 0, "play_move");
    hand_all(650, 715, 840, 3, 0); do_reset(1'b1, "reset_mid_play");
    do_tick(0, 0, 0, "idle_after_reset");

    repeat (4) @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left in scoreboard, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
